mem_arbiter: RTL and testbench

Two-port arbiter that shares the single external memory port between the MIPS core and a loader/debug requester, such as a program loader or DMA engine. It sits between the requesters and `exmemory`. It grants the port to one requester at a time using registered grants, a round-robin tie-break and a bounded hold time. It muxes address, write data and write enable onto the memory, and fans read data back to both sides.

---
 rtl/mem_arbiter_if.sv | 40 ++++
 rtl/mem_arbiter.sv | 143 ++++++++++++++
 tb/tb_mem_arbiter.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_if.sv
// Bundle of the requester-side and memory-side buses around mem_arbiter.
// slave  : the arbiter's view (takes requests and memory read data, drives grants and the memory port)
// master : the view of whoever drives the requests and models the memory
interface mem_arbiter_if #(
    parameter int WIDTH = 8
);
    logic             cpu_req;
    logic [WIDTH-1:0] cpu_adr;
    logic [WIDTH-1:0] cpu_writedata;
    logic             cpu_memwrite;
    logic             cpu_gnt;

    logic             ldr_req;
    logic [WIDTH-1:0] ldr_adr;
    logic [WIDTH-1:0] ldr_writedata;
    logic             ldr_memwrite;
    logic             ldr_gnt;

    logic [WIDTH-1:0] adr;
    logic [WIDTH-1:0] writedata;
    logic             memwrite;
    logic [WIDTH-1:0] memdata;
    logic [WIDTH-1:0] rdata;

    modport slave (
        input  cpu_req, cpu_adr, cpu_writedata, cpu_memwrite,
        input  ldr_req, ldr_adr, ldr_writedata, ldr_memwrite,
        input  memdata,
        output cpu_gnt, ldr_gnt,
        output adr, writedata, memwrite, rdata
    );

    modport master (
        output cpu_req, cpu_adr, cpu_writedata, cpu_memwrite,
        output ldr_req, ldr_adr, ldr_writedata, ldr_memwrite,
        output memdata,
        input  cpu_gnt, ldr_gnt,
        input  adr, writedata, memwrite, rdata
    );
endinterface

// File: rtl/mem_arbiter.sv
// Two-requester arbiter for the single external memory port (MIPS core vs.
// loader/DMA). Registered grants, round-robin tie-break, bounded hold time.
//
// Optional feature: define ARB_FIXED_PRIO_EN to make the loader win every tie
// and to exempt GNT_LDR from the hold limit (bring-up program loading).
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | nobody owns the port; memory port driven to zero
// GNT_CPU | CPU owns the port; hold_cnt counts cycles the loader waits
// GNT_LDR | loader owns the port; hold_cnt counts cycles the CPU waits
//
// WIDTH must match the WIDTH of the connected mem_arbiter_if instance.
module mem_arbiter #(
    parameter int WIDTH = 8,
    parameter int HOLD  = 4
) (
    input  logic          clk,
    input  logic          reset,
    mem_arbiter_if.slave  bus
);
    localparam int CW = (HOLD > 2) ? $clog2(HOLD) : 1;
    localparam logic [CW-1:0] HOLD_MAX = CW'(HOLD - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GNT_CPU = 2'd1,
        GNT_LDR = 2'd2
    } state_t;

    // last side granted: 0 = CPU, 1 = loader
    localparam logic SIDE_CPU = 1'b0;
    localparam logic SIDE_LDR = 1'b1;

    state_t          state_q;
    state_t          state_d;
    logic [CW-1:0]   hold_cnt_q;
    logic [CW-1:0]   hold_cnt_d;
    logic            last_q;
    logic            cpu_gnt_q;
    logic            ldr_gnt_q;
    logic            tie_to_ldr;

    logic [WIDTH-1:0] adr_mux;
    logic [WIDTH-1:0] writedata_mux;

`ifdef ARB_FIXED_PRIO_EN
    assign tie_to_ldr = 1'b1;
`else
    assign tie_to_ldr = (last_q == SIDE_CPU);
`endif

    // Next-state and hold counter; counter stays 0 on any state change or when nobody waits
    always_comb begin
        state_d    = state_q;
        hold_cnt_d = '0;
        case (state_q)
            IDLE: begin
                if (bus.cpu_req && bus.ldr_req) begin
                    state_d = tie_to_ldr ? GNT_LDR : GNT_CPU;
                end else if (bus.cpu_req) begin
                    state_d = GNT_CPU;
                end else if (bus.ldr_req) begin
                    state_d = GNT_LDR;
                end
            end
            GNT_CPU: begin
                if (!bus.cpu_req) begin
                    state_d = bus.ldr_req ? GNT_LDR : IDLE;
                end else if (bus.ldr_req) begin
                    if (hold_cnt_q == HOLD_MAX) begin
                        state_d = GNT_LDR;
                    end else begin
                        hold_cnt_d = hold_cnt_q + 1'b1;
                    end
                end
            end
            GNT_LDR: begin
                if (!bus.ldr_req) begin
                    state_d = bus.cpu_req ? GNT_CPU : IDLE;
                end else if (bus.cpu_req) begin
`ifdef ARB_FIXED_PRIO_EN
                    // loader is never preempted; counter is not needed here
                    hold_cnt_d = '0;
`else
                    if (hold_cnt_q == HOLD_MAX) begin
                        state_d = GNT_CPU;
                    end else begin
                        hold_cnt_d = hold_cnt_q + 1'b1;
                    end
`endif
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State register with grants registered alongside so they come straight from flops
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            hold_cnt_q <= '0;
            last_q     <= SIDE_CPU;
            cpu_gnt_q  <= 1'b0;
            ldr_gnt_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            hold_cnt_q <= hold_cnt_d;
            cpu_gnt_q  <= (state_d == GNT_CPU);
            ldr_gnt_q  <= (state_d == GNT_LDR);
            if (state_d != state_q) begin
                if (state_d == GNT_CPU) begin
                    last_q <= SIDE_CPU;
                end else if (state_d == GNT_LDR) begin
                    last_q <= SIDE_LDR;
                end
            end
        end
    end

    // Memory-port mux; an ungranted side can never reach memory
    always_comb begin
        adr_mux       = '0;
        writedata_mux = '0;
        if (cpu_gnt_q) begin
            adr_mux       = bus.cpu_adr;
            writedata_mux = bus.cpu_writedata;
        end else if (ldr_gnt_q) begin
            adr_mux       = bus.ldr_adr;
            writedata_mux = bus.ldr_writedata;
        end
    end

    assign bus.cpu_gnt   = cpu_gnt_q;
    assign bus.ldr_gnt   = ldr_gnt_q;
    assign bus.adr       = adr_mux;
    assign bus.writedata = writedata_mux;
    assign bus.memwrite  = (bus.cpu_memwrite & cpu_gnt_q) | (bus.ldr_memwrite & ldr_gnt_q);
    assign bus.rdata     = bus.memdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter (WIDTH=8, HOLD=4).
module tb_mem_arbiter;
    logic clk;
    logic reset;
    int   n_checks;
    int   n_fail;

    mem_arbiter_if #(.WIDTH(8)) bus ();

    mem_arbiter #(.WIDTH(8), .HOLD(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        reset    = 1'b0;
        bus.cpu_req = 1'b0; bus.cpu_adr = 8'h00; bus.cpu_writedata = 8'h00; bus.cpu_memwrite = 1'b0;
        bus.ldr_req = 1'b0; bus.ldr_adr = 8'h00; bus.ldr_writedata = 8'h00; bus.ldr_memwrite = 1'b0;
        bus.memdata = 8'h00;

        @(negedge clk);
        check("rst_cpu_gnt",  32'(bus.cpu_gnt),   32'h0);
        check("rst_ldr_gnt",  32'(bus.ldr_gnt),   32'h0);
        check("rst_adr",      32'(bus.adr),       32'h0);
        check("rst_wdata",    32'(bus.writedata), 32'h0);
        check("rst_memwrite", 32'(bus.memwrite),  32'h0);

        reset = 1'b1;
        step();
        check("idle_cpu_gnt", 32'(bus.cpu_gnt), 32'h0);

        // CPU alone; loader drives an ungranted write that must not leak
        bus.cpu_req = 1'b1; bus.cpu_adr = 8'h2c; bus.cpu_writedata = 8'h15; bus.cpu_memwrite = 1'b1;
        bus.ldr_adr = 8'h10; bus.ldr_writedata = 8'hff; bus.ldr_memwrite = 1'b1;
        #1;
        check("pre_gnt_memwrite", 32'(bus.memwrite), 32'h0);
        check("pre_gnt_adr",      32'(bus.adr),      32'h0);
        step();
        check("t1_cpu_gnt",  32'(bus.cpu_gnt),   32'h1);
        check("t1_ldr_gnt",  32'(bus.ldr_gnt),   32'h0);
        check("t1_adr",      32'(bus.adr),       32'h2c);
        check("t1_wdata",    32'(bus.writedata), 32'h15);
        check("t1_memwrite", 32'(bus.memwrite),  32'h1);
        bus.memdata = 8'ha5;
        #1;
        check("t1_rdata", 32'(bus.rdata), 32'ha5);

        bus.cpu_req = 1'b0; bus.cpu_memwrite = 1'b0;
        step();
        check("t1_rel_cpu_gnt",  32'(bus.cpu_gnt),  32'h0);
        check("t1_rel_adr",      32'(bus.adr),      32'h0);
        check("t1_rel_memwrite", 32'(bus.memwrite), 32'h0);

        // tie with last=CPU: loader first, then direct handover back to CPU
        bus.cpu_req = 1'b1; bus.ldr_req = 1'b1;
        bus.ldr_memwrite = 1'b0; bus.ldr_adr = 8'h40; bus.ldr_writedata = 8'h77;
        step();
        check("t2_ldr_gnt", 32'(bus.ldr_gnt),   32'h1);
        check("t2_cpu_gnt", 32'(bus.cpu_gnt),   32'h0);
        check("t2_adr",     32'(bus.adr),       32'h40);
        check("t2_wdata",   32'(bus.writedata), 32'h77);
        step();
        check("t2_ldr_gnt_c2", 32'(bus.ldr_gnt), 32'h1);
        bus.ldr_req = 1'b0;
        step();
        check("t2_handover_cpu_gnt", 32'(bus.cpu_gnt), 32'h1);
        check("t2_handover_ldr_gnt", 32'(bus.ldr_gnt), 32'h0);
        check("t2_handover_adr",     32'(bus.adr),     32'h2c);

        // preemption of CPU after HOLD=4 edges; loader write held off meanwhile
        bus.cpu_memwrite = 1'b1;
        bus.ldr_req = 1'b1; bus.ldr_adr = 8'h10; bus.ldr_memwrite = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            step();
            check("t3_cpu_holds",     32'(bus.cpu_gnt),  32'h1);
            check("t3_ldr_waits",     32'(bus.ldr_gnt),  32'h0);
            check("t3_memwrite_cpu",  32'(bus.memwrite), 32'h1);
            check("t3_adr_cpu",       32'(bus.adr),      32'h2c);
            if (i == 2) begin
                bus.cpu_memwrite = 1'b0;
                #1;
                check("t4_memwrite_follows_cpu", 32'(bus.memwrite), 32'h0);
                bus.cpu_memwrite = 1'b1;
            end
        end
        step();
        check("t3_preempt_ldr_gnt", 32'(bus.ldr_gnt),  32'h1);
        check("t3_preempt_cpu_gnt", 32'(bus.cpu_gnt),  32'h0);
        check("t3_preempt_adr",     32'(bus.adr),      32'h10);
        check("t3_preempt_memwrite",32'(bus.memwrite), 32'h1);

`ifdef ARB_FIXED_PRIO_EN
        // loader keeps the port for 10 cycles despite the waiting CPU
        for (int i = 0; i < 10; i++) begin
            step();
            check("fp_ldr_holds", 32'(bus.ldr_gnt), 32'h1);
        end
        bus.ldr_req = 1'b0;
        step();
        check("fp_cpu_after_release", 32'(bus.cpu_gnt), 32'h1);
`else
        // symmetric hold limit: CPU takes the port back after 4 edges
        for (int i = 0; i < 3; i++) begin
            step();
            check("rr_ldr_holds", 32'(bus.ldr_gnt), 32'h1);
        end
        step();
        check("rr_cpu_preempts", 32'(bus.cpu_gnt), 32'h1);
        check("rr_ldr_dropped",  32'(bus.ldr_gnt), 32'h0);
        bus.ldr_req = 1'b0;
        step();
        check("rr_cpu_stays", 32'(bus.cpu_gnt), 32'h1);
`endif

        // hold counter clears when the waiting side drops its request
        bus.ldr_req = 1'b1;
        step();
        step();
        check("clr_cpu_gnt_a", 32'(bus.cpu_gnt), 32'h1);
        bus.ldr_req = 1'b0;
        step();
        bus.ldr_req = 1'b1;
        step();
        step();
        step();
        check("clr_cpu_gnt_b", 32'(bus.cpu_gnt), 32'h1);
        check("clr_ldr_gnt_b", 32'(bus.ldr_gnt), 32'h0);
        step();
        check("clr_ldr_preempt", 32'(bus.ldr_gnt), 32'h1);

        // asynchronous reset mid-grant, then tie goes to loader again
        #2;
        reset = 1'b0;
        #1;
        check("ar_cpu_gnt",  32'(bus.cpu_gnt),  32'h0);
        check("ar_ldr_gnt",  32'(bus.ldr_gnt),  32'h0);
        check("ar_memwrite", 32'(bus.memwrite), 32'h0);
        check("ar_adr",      32'(bus.adr),      32'h0);
        @(negedge clk);
        reset = 1'b1;
        step();
        check("ar_tie_ldr_gnt", 32'(bus.ldr_gnt), 32'h1);
        check("ar_tie_cpu_gnt", 32'(bus.cpu_gnt), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
